// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module  : mem_port_arbiter
// Brief   : Round-robin arbiter sharing one memory port between IFU and LSU,
//           one outstanding transaction, with response timeout.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int MASK_W  = 8,
    parameter int TIMEOUT = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ifu_req_valid,
    output logic              ifu_req_ready,
    input  logic [ADDR_W-1:0] ifu_addr,
    output logic              ifu_resp_valid,
    output logic [DATA_W-1:0] ifu_rdata,
    output logic              ifu_resp_err,
    input  logic              lsu_req_valid,
    output logic              lsu_req_ready,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic              lsu_wen,
    input  logic [DATA_W-1:0] lsu_wdata,
    input  logic [MASK_W-1:0] lsu_wmask,
    output logic              lsu_resp_valid,
    output logic [DATA_W-1:0] lsu_rdata,
    output logic              lsu_resp_err,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wen,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [MASK_W-1:0] mem_wmask,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] C_CNT_MAX = CW'(TIMEOUT - 1);
    localparam logic C_OWN_IFU = 1'b0;
    localparam logic C_OWN_LSU = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic              r_owner;
    logic              r_last_grant;
    logic [CW-1:0]     r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic              r_wen;
    logic [DATA_W-1:0] r_wdata;
    logic [MASK_W-1:0] r_wmask;

    logic w_grant;
    logic w_grant_lsu;
    logic w_fire;
    logic w_timeout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_owner      <= C_OWN_IFU;
            r_last_grant <= C_OWN_LSU;
            r_cnt        <= '0;
            r_addr       <= '0;
            r_wen        <= 1'b0;
            r_wdata      <= '0;
            r_wmask      <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_grant) begin
                r_owner      <= w_grant_lsu;
                r_last_grant <= w_grant_lsu;
                r_addr       <= w_grant_lsu ? lsu_addr : ifu_addr;
                r_wen        <= w_grant_lsu & lsu_wen;
                r_wdata      <= w_grant_lsu ? lsu_wdata : '0;
                r_wmask      <= w_grant_lsu ? lsu_wmask : '0;
            end
            // Saturating count so the timeout compare can never be re-hit by wrap.
            if (r_state == S_ISSUE && mem_req_ready) begin
                r_cnt <= '0;
            end else if (r_state == S_WAIT && r_cnt != C_CNT_MAX) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_grant      = 1'b0;
        w_grant_lsu  = 1'b0;
        w_fire       = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_grant     = ifu_req_valid | lsu_req_valid;
                w_grant_lsu = (ifu_req_valid & lsu_req_valid) ? ~r_last_grant : lsu_req_valid;
                if (w_grant) w_next_state = S_ISSUE;
            end
            S_ISSUE: begin
                if (mem_req_ready) w_next_state = S_WAIT;
            end
            S_WAIT: begin
                w_timeout = ~mem_resp_valid & (r_cnt == C_CNT_MAX);
                w_fire    = mem_resp_valid | w_timeout;
                if (w_fire) w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Readies are masked by rst so a held request shows no grant while in reset.
    assign ifu_req_ready  = w_grant & ~w_grant_lsu & ~rst;
    assign lsu_req_ready  = w_grant &  w_grant_lsu & ~rst;

    assign ifu_resp_valid = w_fire & (r_owner == C_OWN_IFU);
    assign lsu_resp_valid = w_fire & (r_owner == C_OWN_LSU);
    assign ifu_resp_err   = ifu_resp_valid & w_timeout;
    assign lsu_resp_err   = lsu_resp_valid & w_timeout;
    assign ifu_rdata      = (ifu_resp_valid & ~w_timeout) ? mem_rdata : '0;
    assign lsu_rdata      = (lsu_resp_valid & ~w_timeout) ? mem_rdata : '0;

    assign mem_req_valid  = (r_state == S_ISSUE);
    assign mem_addr       = r_addr;
    assign mem_wen        = r_wen;
    assign mem_wdata      = r_wdata;
    assign mem_wmask      = r_wmask;
    assign busy           = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module  : tb_mem_port_arbiter
// Brief   : Directed self-checking bench for mem_port_arbiter (TIMEOUT=4).
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

    localparam int ADDR_W = 64;
    localparam int DATA_W = 64;
    localparam int MASK_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_err;
    logic [ADDR_W-1:0] ifu_addr;
    logic [DATA_W-1:0] ifu_rdata;
    logic              lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid, lsu_resp_err;
    logic [ADDR_W-1:0] lsu_addr;
    logic [DATA_W-1:0] lsu_wdata, lsu_rdata;
    logic [MASK_W-1:0] lsu_wmask;
    logic              mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid, busy;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;
    logic [MASK_W-1:0] mem_wmask;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W), .TIMEOUT(4)
    ) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata), .ifu_resp_err(ifu_resp_err),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata), .lsu_resp_err(lsu_resp_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    // Advance one cycle; inputs are then driven 1ns after the edge, checks 1ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ifu_req_valid = 0; ifu_addr = '0;
        lsu_req_valid = 0; lsu_addr = '0; lsu_wen = 0; lsu_wdata = '0; lsu_wmask = '0;
        mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] outs;
        clear_inputs();
        rst = 1'b1;
        ifu_req_valid = 1;
        lsu_req_valid = 1;
        step();
        #1;
        outs = {ifu_req_ready, lsu_req_ready, ifu_resp_valid, lsu_resp_valid,
                ifu_resp_err, lsu_resp_err, mem_req_valid, busy};
        checks++;
        if (outs !== 8'h00) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 00000000", outs);
        end
        checks++;
        if ({ifu_rdata, lsu_rdata, mem_addr, mem_wdata, mem_wmask, mem_wen} !== '0) begin
            errors++;
            $display("FAIL reset_data: got ifu_rdata=%h lsu_rdata=%h mem_addr=%h expected 0",
                     ifu_rdata, lsu_rdata, mem_addr);
        end
        do_reset();
    endtask

    task automatic test_ifu_only();
        ifu_req_valid = 1; ifu_addr = 64'h8000_0000; mem_req_ready = 1;
        #1;
        checks++;
        if ({ifu_req_ready, lsu_req_ready} !== 2'b10) begin
            errors++;
            $display("FAIL ifu_t0_ready: got ifu/lsu=%b expected 10", {ifu_req_ready, lsu_req_ready});
        end
        step();
        ifu_req_valid = 0; ifu_addr = 64'h1234;
        #1;
        checks++;
        if ({mem_req_valid, mem_wen, ifu_req_ready, ifu_resp_valid} !== 4'b1000 ||
            mem_addr !== 64'h8000_0000) begin
            errors++;
            $display("FAIL ifu_t1_issue: got valid=%b wen=%b addr=%h expected 1 0 80000000",
                     mem_req_valid, mem_wen, mem_addr);
        end
        step();
        mem_req_ready = 0; mem_resp_valid = 1; mem_rdata = 64'h0000_0013_0010_0073;
        #1;
        checks++;
        if ({ifu_resp_valid, ifu_resp_err, lsu_resp_valid} !== 3'b100 ||
            ifu_rdata !== 64'h0000_0013_0010_0073 || lsu_rdata !== '0) begin
            errors++;
            $display("FAIL ifu_t2_resp: got v=%b e=%b lsu_v=%b rdata=%h expected 1 0 0 0000001300100073",
                     ifu_resp_valid, ifu_resp_err, lsu_resp_valid, ifu_rdata);
        end
        step();
        mem_resp_valid = 0;
        #1;
        checks++;
        if ({busy, ifu_resp_valid, lsu_resp_valid} !== 3'b000) begin
            errors++;
            $display("FAIL ifu_t3_idle: got busy=%b ifu_v=%b lsu_v=%b expected 000",
                     busy, ifu_resp_valid, lsu_resp_valid);
        end
    endtask

    task automatic test_tie();
        logic exp_lsu;
        do_reset();
        ifu_req_valid = 1; ifu_addr = 64'h100;
        lsu_req_valid = 1; lsu_addr = 64'h200;
        mem_req_ready = 1;
        for (int i = 0; i < 6; i++) begin
            exp_lsu = i[0];
            #1;
            checks++;
            if ({ifu_req_ready, lsu_req_ready} !== {~exp_lsu, exp_lsu}) begin
                errors++;
                $display("FAIL tie_grant_%0d: got ifu/lsu=%b expected %b",
                         i, {ifu_req_ready, lsu_req_ready}, {~exp_lsu, exp_lsu});
            end
            step();
            checks++;
            if (mem_addr !== (exp_lsu ? 64'h200 : 64'h100) || {ifu_req_ready, lsu_req_ready} !== 2'b00) begin
                errors++;
                $display("FAIL tie_issue_%0d: got addr=%h readies=%b expected %h 00",
                         i, mem_addr, {ifu_req_ready, lsu_req_ready}, exp_lsu ? 64'h200 : 64'h100);
            end
            step();
            mem_resp_valid = 1; mem_rdata = 64'(i + 1);
            #1;
            checks++;
            if ({ifu_resp_valid, lsu_resp_valid} !== {~exp_lsu, exp_lsu} ||
                (exp_lsu ? lsu_rdata : ifu_rdata) !== 64'(i + 1) ||
                (exp_lsu ? ifu_rdata : lsu_rdata) !== '0) begin
                errors++;
                $display("FAIL tie_resp_%0d: got ifu/lsu valid=%b ifu_rdata=%h lsu_rdata=%h expected %b",
                         i, {ifu_resp_valid, lsu_resp_valid}, ifu_rdata, lsu_rdata, {~exp_lsu, exp_lsu});
            end
            step();
            mem_resp_valid = 0;
        end
        clear_inputs();
    endtask

    task automatic test_lsu_write();
        lsu_req_valid = 1; lsu_wen = 1; lsu_addr = 64'h8000_1008;
        lsu_wdata = 64'hDEAD_BEEF_CAFE_F00D; lsu_wmask = 8'hF0;
        #1;
        checks++;
        if ({ifu_req_ready, lsu_req_ready} !== 2'b01) begin
            errors++;
            $display("FAIL wr_accept: got ifu/lsu=%b expected 01", {ifu_req_ready, lsu_req_ready});
        end
        step();
        lsu_req_valid = 0; lsu_wen = 0; lsu_addr = '1; lsu_wdata = '0; lsu_wmask = '0;
        for (int c = 0; c < 4; c++) begin
            if (c == 3) mem_req_ready = 1;
            #1;
            checks++;
            if ({mem_req_valid, mem_wen} !== 2'b11 || mem_addr !== 64'h8000_1008 ||
                mem_wdata !== 64'hDEAD_BEEF_CAFE_F00D || mem_wmask !== 8'hF0 || lsu_resp_valid !== 1'b0) begin
                errors++;
                $display("FAIL wr_hold_%0d: got v=%b wen=%b addr=%h wdata=%h mask=%h",
                         c, mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wmask);
            end
            step();
        end
        mem_req_ready = 0; mem_resp_valid = 1; mem_rdata = 64'h55;
        #1;
        checks++;
        if ({lsu_resp_valid, lsu_resp_err, ifu_resp_valid} !== 3'b100 || lsu_rdata !== 64'h55) begin
            errors++;
            $display("FAIL wr_ack: got v=%b e=%b ifu_v=%b rdata=%h expected 1 0 0 55",
                     lsu_resp_valid, lsu_resp_err, ifu_resp_valid, lsu_rdata);
        end
        step();
        mem_resp_valid = 0;
        #1;
        checks++;
        if ({lsu_resp_valid, busy} !== 2'b00) begin
            errors++;
            $display("FAIL wr_done: got v=%b busy=%b expected 00", lsu_resp_valid, busy);
        end
    endtask

    task automatic test_timeout();
        lsu_req_valid = 1; lsu_addr = 64'h40; mem_req_ready = 1; mem_rdata = 64'hFFFF;
        step();
        lsu_req_valid = 0;
        step();
        mem_req_ready = 0;
        for (int w = 1; w <= 3; w++) begin
            #1;
            checks++;
            if ({lsu_resp_valid, lsu_resp_err, busy} !== 3'b001) begin
                errors++;
                $display("FAIL to_wait_%0d: got v=%b e=%b busy=%b expected 0 0 1",
                         w, lsu_resp_valid, lsu_resp_err, busy);
            end
            step();
        end
        #1;
        checks++;
        if ({lsu_resp_valid, lsu_resp_err, ifu_resp_valid} !== 3'b110 || lsu_rdata !== '0) begin
            errors++;
            $display("FAIL to_fire: got v=%b e=%b ifu_v=%b rdata=%h expected 1 1 0 0",
                     lsu_resp_valid, lsu_resp_err, ifu_resp_valid, lsu_rdata);
        end
        step();
        #1;
        checks++;
        if ({busy, lsu_resp_valid, lsu_resp_err} !== 3'b000) begin
            errors++;
            $display("FAIL to_idle: got busy=%b v=%b e=%b expected 000", busy, lsu_resp_valid, lsu_resp_err);
        end
        clear_inputs();
    endtask

    task automatic test_stray();
        ifu_req_valid = 1; ifu_addr = 64'h8000_0040;
        step();
        ifu_req_valid = 0; mem_resp_valid = 1; mem_rdata = 64'hBAD;
        #1;
        checks++;
        if ({ifu_resp_valid, lsu_resp_valid, mem_req_valid} !== 3'b001) begin
            errors++;
            $display("FAIL stray_issue: got ifu_v=%b lsu_v=%b req_v=%b expected 001",
                     ifu_resp_valid, lsu_resp_valid, mem_req_valid);
        end
        step();
        mem_resp_valid = 0; mem_req_ready = 1;
        step();
        mem_req_ready = 0; mem_resp_valid = 1; mem_rdata = 64'h600D;
        #1;
        checks++;
        if (ifu_resp_valid !== 1'b1 || ifu_rdata !== 64'h600D) begin
            errors++;
            $display("FAIL stray_resp: got v=%b rdata=%h expected 1 600d", ifu_resp_valid, ifu_rdata);
        end
        step();
        clear_inputs();
    endtask

    task automatic test_reset_in_wait();
        ifu_req_valid = 1; ifu_addr = 64'h8000_0080; mem_req_ready = 1;
        step();
        ifu_req_valid = 0;
        step();
        mem_req_ready = 0; ifu_req_valid = 1;
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, mem_req_valid, ifu_req_ready, lsu_req_ready, ifu_resp_valid, lsu_resp_valid,
             ifu_resp_err, lsu_resp_err} !== 8'h00 || mem_addr !== '0) begin
            errors++;
            $display("FAIL rstwait_outs: got busy=%b req_v=%b ifu_rdy=%b addr=%h expected all 0",
                     busy, mem_req_valid, ifu_req_ready, mem_addr);
        end
        step();
        rst = 1'b0; ifu_req_valid = 0; mem_resp_valid = 1; mem_rdata = 64'h77;
        #1;
        checks++;
        if ({ifu_resp_valid, lsu_resp_valid, busy} !== 3'b000 || ifu_rdata !== '0) begin
            errors++;
            $display("FAIL rstwait_late: got ifu_v=%b lsu_v=%b busy=%b rdata=%h expected 0",
                     ifu_resp_valid, lsu_resp_valid, busy, ifu_rdata);
        end
        step();
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_ifu_only();
        test_tie();
        test_lsu_write();
        test_timeout();
        test_stray();
        test_reset_in_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
